// File: rtl/device_bus_pkg.sv
// Shared types and bus widths for the device bus arbiter and its interface.
//   arb_state_t : arbiter FSM state encoding
//   DEV_AW      : device address width
//   DEV_DW      : device data width
package device_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  localparam int DEV_AW = 32;
  localparam int DEV_DW = 32;

endpackage

// File: rtl/device_bus_arbiter_if.sv
// Requester and device signal bundle for device_bus_arbiter.
// Requester side (NREQ lanes, packed vectors, lane i of addr/data is [32*i +: 32]):
//   req_re, req_we, req_addr, req_wdata   requests into the arbiter
//   req_rack, req_wack, req_err           one-cycle completion pulses to the grantee
//   req_rdata                             read data shared by all requesters
// Device side:
//   dev_en, dev_re, dev_we, dev_addr, dev_wdata   bus drive to the device
//   dev_rdata, dev_rack, dev_wack                 device response
// Modports:
//   master : the arbiter (drives the device bus and the completion pulses)
//   slave  : everything around it (requesters plus device)
interface device_bus_arbiter_if #(
  parameter int NREQ = 2
);
  import device_bus_pkg::*;

  logic [NREQ-1:0]        req_re;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*DEV_AW-1:0] req_addr;
  logic [NREQ*DEV_DW-1:0] req_wdata;
  logic [NREQ-1:0]        req_rack;
  logic [NREQ-1:0]        req_wack;
  logic [NREQ-1:0]        req_err;
  logic [DEV_DW-1:0]      req_rdata;

  logic                   dev_en;
  logic                   dev_re;
  logic                   dev_we;
  logic [DEV_AW-1:0]      dev_addr;
  logic [DEV_DW-1:0]      dev_wdata;
  logic [DEV_DW-1:0]      dev_rdata;
  logic                   dev_rack;
  logic                   dev_wack;

  modport master (
    input  req_re, req_we, req_addr, req_wdata,
    output req_rack, req_wack, req_err, req_rdata,
    output dev_en, dev_re, dev_we, dev_addr, dev_wdata,
    input  dev_rdata, dev_rack, dev_wack
  );

  modport slave (
    output req_re, req_we, req_addr, req_wdata,
    input  req_rack, req_wack, req_err, req_rdata,
    input  dev_en, dev_re, dev_we, dev_addr, dev_wdata,
    output dev_rdata, dev_rack, dev_wack
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req  [N]   : active request lines
//   last       : index granted most recently
//   gnt        : first active index searching last+1, last+2, ... (mod N)
//   any        : at least one request active (gnt is 0 when clear)
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] gnt,
  output logic                 any
);

  typedef logic [$clog2(N)-1:0] idx_t;

  // Walk the rotation from farthest to nearest so the nearest active
  // index after 'last' is the one left standing.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      for (int j = 0; j < N; j++) begin
        if ((j == ((int'(last) + k) % N)) && req[j]) begin
          gnt = idx_t'(j);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/device_bus_arbiter.sv
// Round-robin arbiter sharing one device bus between NREQ requesters.
// A granted transaction owns the bus until the matching device ack or a
// timeout of 2**TMO_W-1 busy cycles, then a one-cycle RACK/WACK/ERR pulse
// goes back to the grantee.
// Ports:
//   clk  : clock, rising edge
//   res  : synchronous reset, active high
//   bus  : device_bus_arbiter_if.master (requester lanes + device bus)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ARB_IDLE | bus free; pick next active requester round-robin
// ARB_BUSY | DEV_* driven from registers; wait for matching ack/timeout
// ARB_RESP | one-cycle done/err pulse to grantee; bus released
module device_bus_arbiter #(
  parameter int NREQ  = 2,
  parameter int TMO_W = 8
) (
  input logic                 clk,
  input logic                 res,
  device_bus_arbiter_if.master bus
);
  import device_bus_pkg::*;

  localparam int LW = $clog2(NREQ);
  typedef logic [LW-1:0] idx_t;

  localparam logic [TMO_W-1:0] CNT_MAX  = '1;
  localparam logic [TMO_W-1:0] CNT_TERM = CNT_MAX - 1'b1;

  arb_state_t        state, state_n;
  idx_t              gnt, gnt_n;
  idx_t              last, last_n;
  logic [TMO_W-1:0]  cnt, cnt_n;
  logic              is_rd, is_rd_n;
  logic [DEV_AW-1:0] addr_q, addr_n;
  logic [DEV_DW-1:0] wdata_q, wdata_n;
  logic              en_q, en_n;
  logic              re_q, re_n;
  logic              we_q, we_n;
  logic [NREQ-1:0]   rack_q, rack_n;
  logic [NREQ-1:0]   wack_q, wack_n;
  logic [NREQ-1:0]   err_q, err_n;
  logic [DEV_DW-1:0] rdata_q, rdata_n;

  logic [NREQ-1:0]   active;
  idx_t              pick;
  logic              pick_any;
  logic              pick_re;
  logic [DEV_AW-1:0] pick_addr;
  logic [DEV_DW-1:0] pick_wdata;
  logic              ack_hit;

  assign active = bus.req_re | bus.req_we;

  rr_picker #(.N(NREQ)) u_pick (
    .req  (active),
    .last (last),
    .gnt  (pick),
    .any  (pick_any)
  );

  always_comb begin
    pick_re    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (idx_t'(j) == pick) begin
        pick_re    = bus.req_re[j];
        pick_addr  = bus.req_addr[DEV_AW*j +: DEV_AW];
        pick_wdata = bus.req_wdata[DEV_DW*j +: DEV_DW];
      end
    end
  end

  // Only the ack matching the latched kind counts; the other one is noise.
  assign ack_hit = is_rd ? bus.dev_rack : bus.dev_wack;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    cnt_n   = cnt;
    is_rd_n = is_rd;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    en_n    = en_q;
    re_n    = re_q;
    we_n    = we_q;
    rack_n  = '0;
    wack_n  = '0;
    err_n   = '0;
    rdata_n = rdata_q;

    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_n = ARB_BUSY;
          gnt_n   = pick;
          cnt_n   = '0;
          // RE beats WE when a requester raises both.
          is_rd_n = pick_re;
          addr_n  = pick_addr;
          wdata_n = pick_wdata;
          en_n    = 1'b1;
          re_n    = pick_re;
          we_n    = ~pick_re;
        end
      end
      ARB_BUSY: begin
        if (cnt != CNT_MAX) cnt_n = cnt + 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (ack_hit) begin
          state_n = ARB_RESP;
          en_n    = 1'b0;
          re_n    = 1'b0;
          we_n    = 1'b0;
          if (is_rd) begin
            rdata_n      = bus.dev_rdata;
            rack_n[gnt]  = 1'b1;
          end else begin
            wack_n[gnt]  = 1'b1;
          end
        end else if (cnt == CNT_TERM) begin
          state_n    = ARB_RESP;
          en_n       = 1'b0;
          re_n       = 1'b0;
          we_n       = 1'b0;
          err_n[gnt] = 1'b1;
        end
      end
      ARB_RESP: begin
        state_n = ARB_IDLE;
        last_n  = gnt;
        cnt_n   = '0;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= ARB_IDLE;
      gnt     <= '0;
      last    <= idx_t'(NREQ - 1);
      cnt     <= '0;
      is_rd   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rack_q  <= '0;
      wack_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      last    <= last_n;
      cnt     <= cnt_n;
      is_rd   <= is_rd_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      en_q    <= en_n;
      re_q    <= re_n;
      we_q    <= we_n;
      rack_q  <= rack_n;
      wack_q  <= wack_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
    end
  end

  assign bus.dev_en    = en_q;
  assign bus.dev_re    = re_q;
  assign bus.dev_we    = we_q;
  assign bus.dev_addr  = addr_q;
  assign bus.dev_wdata = wdata_q;
  assign bus.req_rack  = rack_q;
  assign bus.req_wack  = wack_q;
  assign bus.req_err   = err_q;
  assign bus.req_rdata = rdata_q;

endmodule

// File: tb/tb_device_bus_arbiter.sv
// Bench for device_bus_arbiter: directed requester/device scenarios, a
// transaction-level reference model compared every cycle, and literal
// expectations per scenario.
module tb_device_bus_arbiter;
  import device_bus_pkg::*;

  localparam int NREQ    = 2;
  localparam int TMO_W   = 4;
  localparam int TMO_LIM = (1 << TMO_W) - 1;
  localparam logic [31:0] RD_XOR = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  device_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  device_bus_arbiter #(.NREQ(NREQ), .TMO_W(TMO_W)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // ---------------- stimulus drivers ----------------
  logic [NREQ-1:0]    drv_re    = '0;
  logic [NREQ-1:0]    drv_we    = '0;
  logic [NREQ*32-1:0] drv_addr  = '0;
  logic [NREQ*32-1:0] drv_wdata = '0;
  logic               d_rack    = 1'b0;
  logic               d_wack    = 1'b0;
  logic [31:0]        d_rdata   = 32'hBAD0BAD0;

  assign bus.req_re    = drv_re;
  assign bus.req_we    = drv_we;
  assign bus.req_addr  = drv_addr;
  assign bus.req_wdata = drv_wdata;
  assign bus.dev_rack  = d_rack;
  assign bus.dev_wack  = d_wack;
  assign bus.dev_rdata = d_rdata;

  typedef struct {
    bit          re;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t rq [NREQ][$];
  bit   pres [NREQ];

  // Requesters: present the next queued transaction, hold it until the
  // ack/err cycle, then drop so the arbiter sees it gone at the closing edge.
  always @(negedge clk) begin
    txn_t t;
    for (int i = 0; i < NREQ; i++) begin
      if (pres[i]) begin
        if (bus.req_rack[i] || bus.req_wack[i] || bus.req_err[i]) begin
          pres[i]   = 1'b0;
          drv_re[i] = 1'b0;
          drv_we[i] = 1'b0;
        end
      end else if (rq[i].size() > 0) begin
        t = rq[i].pop_front();
        pres[i] = 1'b1;
        drv_re[i] = t.re;
        drv_we[i] = t.we;
        drv_addr[32*i +: 32]  = t.addr;
        drv_wdata[32*i +: 32] = t.wdata;
      end
    end
  end

  // Device: mode 0 never acks, mode 1 acks on the dev_delay-th enabled cycle,
  // mode 2 drives the wrong-kind ack before that cycle.
  int dev_mode  = 1;
  int dev_delay = 1;
  int dev_cnt   = 0;
  always @(negedge clk) begin
    if (bus.dev_en) dev_cnt++;
    else dev_cnt = 0;
    d_rack  = 1'b0;
    d_wack  = 1'b0;
    d_rdata = 32'hBAD0BAD0;
    if (bus.dev_en && dev_mode != 0) begin
      if (dev_cnt == dev_delay) begin
        d_rack  = bus.dev_re;
        d_wack  = bus.dev_we;
        d_rdata = bus.dev_addr ^ RD_XOR;
      end else if (dev_mode == 2 && dev_cnt < dev_delay) begin
        d_rack = bus.dev_we;
        d_wack = bus.dev_re;
      end
    end
  end

  // ---------------- reference model ----------------
  // Owner of the bus (-1 free), cycles it has held the bus, and a pending
  // response (0 none, 1 read done, 2 write done, 3 timeout) for m_who.
  int          m_owner = -1;
  int          m_age   = 0;
  int          m_resp  = 0;
  int          m_who   = 0;
  int          m_last  = NREQ - 1;
  bit          m_rd    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  bit          started = 1'b0;

  always @(posedge clk) begin
    bit found;
    started = 1'b1;
    if (res) begin
      m_owner = -1;
      m_resp  = 0;
      m_age   = 0;
      m_last  = NREQ - 1;
      m_rdata = '0;
    end else if (m_resp != 0) begin
      m_last = m_who;
      m_resp = 0;
    end else if (m_owner >= 0) begin
      m_age++;
      if (m_rd ? d_rack : d_wack) begin
        if (m_rd) m_rdata = d_rdata;
        m_resp  = m_rd ? 1 : 2;
        m_who   = m_owner;
        m_owner = -1;
      end else if (m_age == TMO_LIM) begin
        m_resp  = 3;
        m_who   = m_owner;
        m_owner = -1;
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_last + k) % NREQ;
        if (!found && (drv_re[j] || drv_we[j])) begin
          found   = 1'b1;
          m_owner = j;
          m_rd    = drv_re[j];
          m_addr  = drv_addr[32*j +: 32];
          m_wdata = drv_wdata[32*j +: 32];
          m_age   = 0;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NREQ-1:0] e_rack, e_wack, e_err;
    bit e_en;
    if (started) begin
      e_en   = (m_owner >= 0);
      e_rack = (m_resp == 1) ? (NREQ'(1) << m_who) : '0;
      e_wack = (m_resp == 2) ? (NREQ'(1) << m_who) : '0;
      e_err  = (m_resp == 3) ? (NREQ'(1) << m_who) : '0;
      check("cyc_dev_en", 32'(bus.dev_en), 32'(e_en));
      check("cyc_dev_re", 32'(bus.dev_re), 32'(e_en && m_rd));
      check("cyc_dev_we", 32'(bus.dev_we), 32'(e_en && !m_rd));
      check("cyc_req_rack", 32'(bus.req_rack), 32'(e_rack));
      check("cyc_req_wack", 32'(bus.req_wack), 32'(e_wack));
      check("cyc_req_err", 32'(bus.req_err), 32'(e_err));
      check("cyc_req_rdata", bus.req_rdata, m_rdata);
      if (e_en) check("cyc_dev_addr", bus.dev_addr, m_addr);
      if (e_en && !m_rd) check("cyc_dev_wdata", bus.dev_wdata, m_wdata);
    end
  end

  // ---------------- observation logs ----------------
  logic [31:0] glog_addr [$];
  bit          glog_re   [$];
  bit          glog_we   [$];
  logic [31:0] rlog      [$];
  int          en_len      = 0;
  int          last_en_len = 0;
  bit          en_prev     = 1'b0;
  int          rack_cnt [NREQ] = '{default: 0};
  int          wack_cnt [NREQ] = '{default: 0};
  int          err_cnt  [NREQ] = '{default: 0};

  always @(negedge clk) begin
    if (bus.dev_en) begin
      if (!en_prev) begin
        glog_addr.push_back(bus.dev_addr);
        glog_re.push_back(bus.dev_re);
        glog_we.push_back(bus.dev_we);
      end
      en_len++;
    end else if (en_prev) begin
      last_en_len = en_len;
      en_len = 0;
    end
    en_prev = bus.dev_en;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_rack[i]) begin
        rack_cnt[i]++;
        rlog.push_back(bus.req_rdata);
      end
      if (bus.req_wack[i]) wack_cnt[i]++;
      if (bus.req_err[i])  err_cnt[i]++;
    end
  end

  function automatic bit quiet();
    return rq[0].size() == 0 && rq[1].size() == 0 && !pres[0] && !pres[1] &&
           !bus.dev_en && m_owner < 0 && m_resp == 0;
  endfunction

  task automatic wait_quiet(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!quiet() && n < budget);
    check({nm, "_completes"}, 32'(quiet()), 32'd1);
  endtask

  task automatic clear_logs();
    glog_addr.delete();
    glog_re.delete();
    glog_we.delete();
    rlog.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int r0, r1, w0, w1, e0;

    res = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dev_en", 32'(bus.dev_en), 32'd0);
    check("rst_dev_addr", bus.dev_addr, 32'd0);
    check("rst_req_rdata", bus.req_rdata, 32'd0);
    check("rst_acks", 32'({bus.req_rack, bus.req_wack, bus.req_err}), 32'd0);
    res = 1'b0;

    // 1: simultaneous reads after reset, requester 0 first
    clear_logs();
    dev_mode = 1; dev_delay = 1;
    rq[0].push_back('{1'b1, 1'b0, 32'h100, 32'h0});
    rq[1].push_back('{1'b1, 1'b0, 32'h200, 32'h0});
    wait_quiet(100, "t1");
    check("t1_ngrants", glog_addr.size(), 2);
    if (glog_addr.size() >= 2) begin
      check("t1_first_addr", glog_addr[0], 32'h100);
      check("t1_second_addr", glog_addr[1], 32'h200);
    end

    // 2: continuous reads alternate 0,1,0,1
    clear_logs();
    rq[0].push_back('{1'b1, 1'b0, 32'h10, 32'h0});
    rq[0].push_back('{1'b1, 1'b0, 32'h14, 32'h0});
    rq[1].push_back('{1'b1, 1'b0, 32'h20, 32'h0});
    rq[1].push_back('{1'b1, 1'b0, 32'h24, 32'h0});
    wait_quiet(200, "t2");
    check("t2_ngrants", glog_addr.size(), 4);
    check("t2_nrack", rlog.size(), 4);
    if (glog_addr.size() >= 4 && rlog.size() >= 4) begin
      check("t2_g0", glog_addr[0], 32'h10);
      check("t2_g1", glog_addr[1], 32'h20);
      check("t2_g2", glog_addr[2], 32'h14);
      check("t2_g3", glog_addr[3], 32'h24);
      check("t2_rd0", rlog[0], 32'hA5A5A5B5);
      check("t2_rd1", rlog[1], 32'hA5A5A585);
      check("t2_rd2", rlog[2], 32'hA5A5A5B1);
      check("t2_rd3", rlog[3], 32'hA5A5A581);
    end

    // 3: requester 1 write with a 5-cycle device ack
    clear_logs();
    w0 = wack_cnt[0]; w1 = wack_cnt[1];
    dev_delay = 5;
    rq[1].push_back('{1'b0, 1'b1, 32'h40, 32'hDEADBEEF});
    wait_quiet(100, "t3");
    check("t3_en_len", last_en_len, 5);
    check("t3_wack1", wack_cnt[1] - w1, 1);
    check("t3_wack0", wack_cnt[0] - w0, 0);
    if (glog_we.size() >= 1) check("t3_dev_we", 32'(glog_we[0]), 32'd1);

    // 4: timeout with no ack, then ack exactly on the last allowed cycle
    clear_logs();
    r0 = rack_cnt[0]; e0 = err_cnt[0];
    dev_mode = 0;
    rq[0].push_back('{1'b1, 1'b0, 32'h300, 32'h0});
    wait_quiet(100, "t4a");
    check("t4a_en_len", last_en_len, 15);
    check("t4a_err0", err_cnt[0] - e0, 1);
    check("t4a_no_rack", rack_cnt[0] - r0, 0);
    r0 = rack_cnt[0]; e0 = err_cnt[0];
    dev_mode = 1; dev_delay = 15;
    rq[0].push_back('{1'b1, 1'b0, 32'h304, 32'h0});
    wait_quiet(100, "t4b");
    check("t4b_en_len", last_en_len, 15);
    check("t4b_rack0", rack_cnt[0] - r0, 1);
    check("t4b_no_err", err_cnt[0] - e0, 0);
    if (rlog.size() >= 1) check("t4b_rdata", rlog[rlog.size()-1], 32'hA5A5A6A1);

    // 5: reset on the 3rd busy cycle of a grant to requester 1
    clear_logs();
    dev_mode = 0;
    rq[0].push_back('{1'b1, 1'b0, 32'h600, 32'h0});
    rq[1].push_back('{1'b1, 1'b0, 32'h700, 32'h0});
    n = 0;
    while (en_len < 3 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_reach_busy3", en_len, 3);
    if (glog_addr.size() >= 1) check("t5_pre_rst_gnt", glog_addr[0], 32'h700);
    r0 = rack_cnt[0]; r1 = rack_cnt[1]; e0 = err_cnt[0];
    res = 1'b1;
    @(negedge clk);
    #1;
    check("t5_rst_dev_en", 32'(bus.dev_en), 32'd0);
    check("t5_rst_dev_re", 32'(bus.dev_re), 32'd0);
    check("t5_rst_addr", bus.dev_addr, 32'd0);
    check("t5_rst_acks", 32'({bus.req_rack, bus.req_wack, bus.req_err}), 32'd0);
    res = 1'b0;
    clear_logs();
    dev_mode = 1; dev_delay = 1;
    wait_quiet(100, "t5");
    check("t5_ngrants", glog_addr.size(), 2);
    if (glog_addr.size() >= 2) begin
      check("t5_first_after_rst", glog_addr[0], 32'h600);
      check("t5_second_after_rst", glog_addr[1], 32'h700);
    end
    check("t5_rack0", rack_cnt[0] - r0, 1);
    check("t5_rack1", rack_cnt[1] - r1, 1);
    check("t5_no_err", err_cnt[0] - e0, 0);

    // 6: RE and WE together -> read; lone WACK ignored
    clear_logs();
    r0 = rack_cnt[0]; w0 = wack_cnt[0];
    dev_mode = 2; dev_delay = 3;
    rq[0].push_back('{1'b1, 1'b1, 32'h500, 32'h12345678});
    wait_quiet(100, "t6");
    if (glog_addr.size() >= 1) begin
      check("t6_addr", glog_addr[0], 32'h500);
      check("t6_dev_re", 32'(glog_re[0]), 32'd1);
      check("t6_dev_we", 32'(glog_we[0]), 32'd0);
    end
    check("t6_en_len", last_en_len, 3);
    check("t6_rack0", rack_cnt[0] - r0, 1);
    check("t6_no_wack", wack_cnt[0] - w0, 0);
    if (rlog.size() >= 1) check("t6_rdata", rlog[rlog.size()-1], 32'hA5A5A0A5);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
